// File: rtl/fmt_sched.sv
// Round-robin scheduler that renders one requester's byte as an ASCII string (dec/bin/oct/hex).
// Optional feature: define FMT_RADIX_PREFIX_EN to prepend "0b"/"0o"/"0x" to non-decimal strings.
module fmt_sched #(
  parameter int NREQ = 4,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ*2-1:0] req_radix,
  output logic [NREQ-1:0]   ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last,
  output logic              busy,
  output logic [GW-1:0]     gnt_id
);

`ifdef FMT_RADIX_PREFIX_EN
  localparam int PFX  = 2;
`else
  localparam int PFX  = 0;
`endif
  localparam int MAXC = PFX + 8;
  localparam int LW   = 4;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  state_t          state_reg;
  logic [GW-1:0]   ptr_reg;
  logic [7:0]      data_reg;
  logic [1:0]      radix_reg;
  logic [7:0]      char_buf_reg [MAXC];
  logic [LW-1:0]   rem_reg;

  logic [7:0]      data_arr  [NREQ];
  logic [1:0]      radix_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi]  = req_data[8*gi +: 8];
      assign radix_arr[gi] = req_radix[2*gi +: 2];
    end
  endgenerate

  assign busy = (state_reg != IDLE);

  // A requester whose ack is high this cycle may still be holding req; mask it so it is not re-served.
  logic [NREQ-1:0] req_eff;
  logic            sel_found;
  logic [GW-1:0]   sel_id;

  always_comb begin
    req_eff   = req & ~ack;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_eff[(int'(ptr_reg) + k) % NREQ]) begin
        sel_found = 1'b1;
        sel_id    = GW'((int'(ptr_reg) + k) % NREQ);
      end
    end
  end

  function automatic logic [7:0] digit_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h57 + {4'h0, v});
  endfunction

  logic [7:0]    conv_buf [MAXC];
  logic [LW-1:0] conv_len;
  logic [3:0]    dec_h, dec_t, dec_o;

  always_comb begin
    for (int k = 0; k < MAXC; k++) conv_buf[k] = 8'h30;
    conv_len = LW'(1);
    dec_h    = 4'(data_reg / 8'd100);
    dec_t    = 4'((data_reg / 8'd10) % 8'd10);
    dec_o    = 4'(data_reg % 8'd10);
    case (radix_reg)
      2'd0: begin
        if (data_reg >= 8'd100) begin
          conv_buf[0] = digit_char(dec_h);
          conv_buf[1] = digit_char(dec_t);
          conv_buf[2] = digit_char(dec_o);
          conv_len    = LW'(3);
        end else if (data_reg >= 8'd10) begin
          conv_buf[0] = digit_char(dec_t);
          conv_buf[1] = digit_char(dec_o);
          conv_len    = LW'(2);
        end else begin
          conv_buf[0] = digit_char(dec_o);
          conv_len    = LW'(1);
        end
      end
      2'd1: begin
        for (int k = 0; k < 8; k++) conv_buf[PFX + k] = {7'b0011000, data_reg[7 - k]};
        conv_len = LW'(PFX + 8);
      end
      2'd2: begin
        conv_buf[PFX]     = digit_char({2'b00, data_reg[7:6]});
        conv_buf[PFX + 1] = digit_char({1'b0, data_reg[5:3]});
        conv_buf[PFX + 2] = digit_char({1'b0, data_reg[2:0]});
        conv_len          = LW'(PFX + 3);
      end
      default: begin
        conv_buf[PFX]     = digit_char(data_reg[7:4]);
        conv_buf[PFX + 1] = digit_char(data_reg[3:0]);
        conv_len          = LW'(PFX + 2);
      end
    endcase
`ifdef FMT_RADIX_PREFIX_EN
    if (radix_reg != 2'd0) begin
      conv_buf[0] = 8'h30;
      case (radix_reg)
        2'd1:    conv_buf[1] = 8'h62;
        2'd2:    conv_buf[1] = 8'h6f;
        default: conv_buf[1] = 8'h78;
      endcase
    end
`endif
  end

  // The buffer shifts left on every accepted character, so slot 1 always holds the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      data_reg  <= '0;
      radix_reg <= '0;
      rem_reg   <= '0;
      for (int k = 0; k < MAXC; k++) char_buf_reg[k] <= '0;
      ack       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_char  <= '0;
      gnt_id    <= '0;
    end else begin
      ack <= '0;
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            gnt_id    <= sel_id;
            data_reg  <= data_arr[sel_id];
            radix_reg <= radix_arr[sel_id];
            state_reg <= CONV;
          end
        end
        CONV: begin
          for (int k = 0; k < MAXC; k++) char_buf_reg[k] <= conv_buf[k];
          rem_reg   <= conv_len - LW'(1);
          out_char  <= conv_buf[0];
          out_last  <= (conv_len == LW'(1));
          out_valid <= 1'b1;
          state_reg <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              ack[gnt_id] <= 1'b1;
              ptr_reg     <= (gnt_id == GW'(NREQ - 1)) ? '0 : gnt_id + GW'(1);
              state_reg   <= IDLE;
            end else begin
              for (int k = 0; k < MAXC - 1; k++) char_buf_reg[k] <= char_buf_reg[k + 1];
              out_char <= char_buf_reg[1];
              out_last <= (rem_reg == LW'(1));
              rem_reg  <= rem_reg - LW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmt_sched.sv
// Self-checking bench for fmt_sched: vector table, hand-written corner sequences, randomized rounds vs a string model.
module tb_fmt_sched;
  localparam int NREQ = 4;
  localparam int GW   = 2;
`ifdef FMT_RADIX_PREFIX_EN
  localparam int TB_PFX = 2;
`else
  localparam int TB_PFX = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ*2-1:0] req_radix;
  logic [NREQ-1:0]   ack;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_char;
  logic              out_last;
  logic              busy;
  logic [GW-1:0]     gnt_id;

  int n_cmp = 0;
  int n_bad = 0;
  int model_ptr = 0;

  fmt_sched #(.NREQ(NREQ), .GW(GW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_radix(req_radix),
    .ack(ack), .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_last(out_last), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [1:0] radix;
    string      exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic string add_prefix(input string s, input logic [1:0] r);
    string p;
    p = "";
`ifdef FMT_RADIX_PREFIX_EN
    case (r)
      2'd1:    p = "0b";
      2'd2:    p = "0o";
      2'd3:    p = "0x";
      default: p = "";
    endcase
`endif
    return {p, s};
  endfunction

  function automatic string fmt_model(input logic [7:0] d, input logic [1:0] r);
    string s;
    case (r)
      2'd0:    s = $sformatf("%0d", d);
      2'd1:    s = $sformatf("%b", d);
      2'd2:    s = $sformatf("%o", d);
      default: s = $sformatf("%h", d);
    endcase
    return add_prefix(s, r);
  endfunction

  task automatic set_req(input int id, input logic [7:0] d, input logic [1:0] r);
    req_data[8*id +: 8]  = d;
    req_radix[2*id +: 2] = r;
    req[id]              = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one string: wait for grant, consume characters (optional stall / random backpressure), check ack.
  task automatic collect(input int id, input string s, input bit rnd, input int stall_pos, input int stall_len);
    int  n, pos, guard, stall;
    bit  rdy;
    guard = 0;
    while (!busy && guard < 20) begin
      tick();
      guard++;
    end
    check("grant_busy", busy, 1);
    check("gnt_id", gnt_id, id);
    check("conv_valid_low", out_valid, 0);
    tick();
    n = s.len();
    pos = 0;
    stall = 0;
    guard = 0;
    while (pos < n && guard < 200) begin
      check("out_valid", out_valid, 1);
      check("out_char", out_char, s[pos]);
      check("out_last", out_last, (pos == n - 1));
      check("ack_quiet", ack, 0);
      if (pos == stall_pos && stall < stall_len) begin
        rdy = 1'b0;
        stall++;
      end else if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      out_ready = rdy;
      if (rdy) pos++;
      tick();
      guard++;
    end
    out_ready = 1'b1;
    check("ack_pulse", ack, 32'(1 << id));
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
    req[id] = 1'b0;
    tick();
    check("ack_clear", ack, 0);
    model_ptr = (id + 1) % NREQ;
    $display("xfer id=%0d str=\"%s\"", id, s);
  endtask

  vec_t vecs[8];

  initial begin
    int guard;
    logic [7:0] rdata [NREQ];
    logic [1:0] rrad  [NREQ];
    logic [NREQ-1:0] mask;

    vecs[0] = '{0, 8'd0,   2'd0, "0"};
    vecs[1] = '{1, 8'hA5,  2'd3, "a5"};
    vecs[2] = '{2, 8'd200, 2'd0, "200"};
    vecs[3] = '{3, 8'd7,   2'd0, "7"};
    vecs[4] = '{0, 8'h81,  2'd1, "10000001"};
    vecs[5] = '{1, 8'hFF,  2'd2, "377"};
    vecs[6] = '{2, 8'h0F,  2'd3, "0f"};
    vecs[7] = '{3, 8'd10,  2'd0, "10"};

    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    req_radix = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ack", ack, 0);
    check("rst_gnt", gnt_id, 0);
    check("rst_char", out_char, 0);
    check("rst_last", out_last, 0);
    rst_n = 1'b1;
    tick();

    // All four requesting from reset: strict 0,1,2,3 order, then 3 and 0 -> 0 first.
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'd20 + i), 2'(i));
    for (int i = 0; i < NREQ; i++) collect(i, fmt_model(8'(8'd20 + i), 2'(i)), 1'b0, -1, 0);
    set_req(3, 8'h3C, 2'd3);
    set_req(0, 8'h05, 2'd2);
    collect(0, fmt_model(8'h05, 2'd2), 1'b0, -1, 0);
    collect(3, fmt_model(8'h3C, 2'd3), 1'b0, -1, 0);

    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].id, vecs[v].data, vecs[v].radix);
      collect(vecs[v].id, add_prefix(vecs[v].exp, vecs[v].radix), 1'b0, -1, 0);
    end

    // Backpressure on the second binary digit for five cycles.
    set_req(0, 8'h81, 2'd1);
    collect(0, add_prefix("10000001", 2'd1), 1'b0, TB_PFX + 1, 5);

    // Reset in the middle of emitting requester 3 (pointer was at 2).
    set_req(1, 8'd42, 2'd0);
    collect(1, "42", 1'b0, -1, 0);
    set_req(3, 8'h81, 2'd1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      tick();
      guard++;
    end
    check("pre_rst_gnt", gnt_id, 3);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_gnt", gnt_id, 0);
    check("mid_rst_char", out_char, 0);
    check("mid_rst_last", out_last, 0);
    tick();
    check("rst_hold_ack", ack, 0);
    tick();
    rst_n = 1'b1;
    model_ptr = 0;
    set_req(0, 8'd99, 2'd0);
    collect(0, "99", 1'b0, -1, 0);
    collect(3, fmt_model(8'h81, 2'd1), 1'b0, -1, 0);

    // Randomized rounds against the round-robin / string model.
    for (int r = 0; r < 30; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) begin
          rdata[i] = 8'($urandom_range(0, 255));
          rrad[i]  = 2'($urandom_range(0, 3));
          set_req(i, rdata[i], rrad[i]);
        end
      end
      while (mask != '0) begin
        int nid;
        nid = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (mask[(model_ptr + k) % NREQ]) nid = (model_ptr + k) % NREQ;
        end
        mask[nid] = 1'b0;
        collect(nid, fmt_model(rdata[nid], rrad[nid]), 1'b1, -1, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fmt_sched.md
FMT_SCHED -- requirements
Module: fmt_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter GW, default $clog2(NREQ), grant-index width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NREQ  per-requester format request, held until ack.
REQ-006 SHALL have port req_data  input  NREQ*8  byte per requester, requester i at [8i+7:8i].
REQ-007 SHALL have port req_radix  input  NREQ*2  per-requester radix: 0 dec (%0d), 1 bin (%b), 2 oct (%o), 3 hex (%h).
REQ-008 SHALL have port ack  output  NREQ  one-cycle completion pulse to the served requester.
REQ-009 SHALL have port out_valid  output  1  character valid.
REQ-010 SHALL have port out_ready  input  1  sink ready.
REQ-011 SHALL have port out_char  output  8  ASCII character.
REQ-012 SHALL have port out_last  output  1  marks final character of a string.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port gnt_id  output  GW  index of the requester being served; valid while busy.

Function
REQ-015 SHALL implement FSM states IDLE, CONV, EMIT.
REQ-016 SHALL, in IDLE with any req bit high, select a requester round-robin starting at pointer ptr, capture its data and radix, set gnt_id, and go to CONV on that edge.
REQ-017 SHALL, in CONV, load a character buffer (max 10 chars) and length, then go to EMIT on the next edge; out_valid goes high one cycle after entering CONV.
REQ-018 SHALL format digits MSB-first in ASCII '0'-'9', 'a'-'f': dec has no leading zeros (value 0 gives "0"), 1-3 chars; bin exactly 8 chars; oct exactly 3 chars; hex exactly 2 chars.
REQ-019 SHALL advance one character per out_valid&&out_ready edge; out_char and out_last SHALL hold stable while out_valid&&!out_ready.
REQ-020 SHALL assert out_last only with the final character.
REQ-021 SHALL, on the handshake of the last character, pulse ack[gnt_id] for exactly one cycle, set ptr to gnt_id+1 modulo NREQ, and return to IDLE.
REQ-022 SHALL ignore req changes while busy; a requester deasserting req early SHALL still be served to completion.
REQ-023 SHALL take at least one IDLE cycle between strings (no back-to-back grant on the ack edge).
REQ-024 SHALL drive out_valid low in IDLE and CONV.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, ptr 0, ack 0, out_valid 0, out_last 0, out_char 0, busy 0, gnt_id 0, regardless of operation in progress.
REQ-026 SHALL discard any partially emitted string on reset; no ack is issued for it.

Configuration
REQ-027 SHALL support macro FMT_RADIX_PREFIX_EN.
REQ-028 SHALL, with FMT_RADIX_PREFIX_EN defined, prepend "0b" (bin), "0o" (oct), "0x" (hex) before the digits; dec gets no prefix.
REQ-029 SHALL, without FMT_RADIX_PREFIX_EN, emit digits only; buffer may shrink to 8 chars.

Verification
REQ-030 SHALL cover: req[0]=1, data 8'd0, radix 0, out_ready=1 -> single char 0x30 with out_last, ack[0] pulse, busy low after.
REQ-031 SHALL cover: req[1]=1, data 8'hA5, radix 3 -> "a","5" (0x61,0x35); with FMT_RADIX_PREFIX_EN -> "0","x","a","5".
REQ-032 SHALL cover: dec 8'd200 -> "200"; dec 8'd7 -> "7"; bin 8'h81 -> "10000001"; oct 8'hFF -> "377".
REQ-033 SHALL cover: all four req high from reset (ptr 0) -> grants 0,1,2,3 in order, each with one ack; then req[3] and req[0] high -> req[0] served first.
REQ-034 SHALL cover: out_ready low 5 cycles after second char of bin 8'h81 -> out_char stays 0x30, out_valid stays 1, resumes in order.
REQ-035 SHALL cover: rst_n low mid-EMIT -> out_valid, busy, ack 0 immediately; after release, next request of requester 0 granted first.
